// File: rtl/day3_fa_response_checker.sv
// On-chip response checker for a full adder: accepts each applied vector, waits for the
// adder to settle, compares its sum/cout with the golden result and accumulates mismatches.
module day3_fa_response_checker #(
  parameter int NUM_VECTORS   = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic                 vec_valid_i,
  input  logic [2:0]           vec_i,
  output logic                 vec_ready_o,
  input  logic                 sum_i,
  input  logic                 cout_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic                 first_err_valid_o,
  output logic [2:0]           first_err_vec_o
);

  localparam int VCNT_W = $clog2(NUM_VECTORS + 1);
  localparam int SCNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VEC,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [2:0]           vec_q, vec_d;
  logic [VCNT_W-1:0]    vec_cnt_q, vec_cnt_d;
  logic [SCNT_W-1:0]    settle_cnt_q, settle_cnt_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 first_err_valid_q, first_err_valid_d;
  logic [2:0]           first_err_vec_q, first_err_vec_d;
  logic                 ready_q, busy_q, done_q, pass_q;
  logic                 exp_sum, exp_cout, mismatch;

  always_comb begin
    state_d           = state_q;
    vec_d             = vec_q;
    vec_cnt_d         = vec_cnt_q;
    settle_cnt_d      = settle_cnt_q;
    err_cnt_d         = err_cnt_q;
    first_err_valid_d = first_err_valid_q;
    first_err_vec_d   = first_err_vec_q;

    exp_sum  = ^vec_q;
    exp_cout = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
    mismatch = ({sum_i, cout_i} != {exp_sum, exp_cout});

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d           = WAIT_VEC;
          vec_cnt_d         = '0;
          err_cnt_d         = '0;
          first_err_valid_d = 1'b0;
          first_err_vec_d   = '0;
        end
      end
      WAIT_VEC: begin
        if (vec_valid_i && ready_q) begin
          vec_d = vec_i;
          if (SETTLE_CYCLES == 0) begin
            state_d = CHECK;
          end else begin
            state_d      = SETTLE;
            settle_cnt_d = SCNT_W'(SETTLE_CYCLES);
          end
        end
      end
      SETTLE: begin
        settle_cnt_d = settle_cnt_q - SCNT_W'(1);
        if (settle_cnt_q == SCNT_W'(1)) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        // Only the first mismatch of a run is captured; the counter sticks at all-ones.
        if (mismatch) begin
          if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          if (!first_err_valid_q) begin
            first_err_valid_d = 1'b1;
            first_err_vec_d   = vec_q;
          end
        end
        vec_cnt_d = vec_cnt_q + VCNT_W'(1);
        if (vec_cnt_d == VCNT_W'(NUM_VECTORS)) begin
          state_d = DONE;
        end else begin
          state_d = WAIT_VEC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they align with the state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q           <= IDLE;
      vec_q             <= '0;
      vec_cnt_q         <= '0;
      settle_cnt_q      <= '0;
      err_cnt_q         <= '0;
      first_err_valid_q <= 1'b0;
      first_err_vec_q   <= '0;
      ready_q           <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      vec_q             <= vec_d;
      vec_cnt_q         <= vec_cnt_d;
      settle_cnt_q      <= settle_cnt_d;
      err_cnt_q         <= err_cnt_d;
      first_err_valid_q <= first_err_valid_d;
      first_err_vec_q   <= first_err_vec_d;
      ready_q           <= (state_d == WAIT_VEC);
      busy_q            <= (state_d == WAIT_VEC) || (state_d == SETTLE) || (state_d == CHECK);
      done_q            <= (state_d == DONE);
      pass_q            <= (state_d == DONE) && (err_cnt_d == '0);
    end
  end

  assign vec_ready_o       = ready_q;
  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign pass_o            = pass_q;
  assign err_cnt_o         = err_cnt_q;
  assign first_err_valid_o = first_err_valid_q;
  assign first_err_vec_o   = first_err_vec_q;

endmodule
